// File: rtl/recompositor_division.sv
// Recompositor: NUM = COC*DEN + RES (inverse of the signed divider), one shift-add step per clock.
// Optional overflow detection is built when RECOMPOSITOR_OVF_DETECT_EN is defined; otherwise ovf is tied to 0.
module recompositor_division #(
    parameter int tamanyo = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [tamanyo-1:0] coc,
    input  logic [tamanyo-1:0] den,
    input  logic [tamanyo-1:0] res,
    output logic [tamanyo-1:0] num,
    output logic               done,
    output logic               ovf
);

    localparam int CW = (tamanyo > 1) ? $clog2(tamanyo) : 1;
    localparam logic [CW-1:0] LAST = CW'(tamanyo - 1);
    localparam logic [tamanyo-1:0] ONE_W = tamanyo'(1);

    typedef enum logic [2:0] {IDLE, CARGA, ITERA, SUMA, FIN} state_t;

    state_t                 state_reg, state_next;
    logic [tamanyo-1:0]     coc_reg, coc_next;
    logic [tamanyo-1:0]     den_reg, den_next;
    logic [tamanyo-1:0]     res_reg, res_next;
    logic [2*tamanyo-1:0]   mcand_reg, mcand_next;
    logic [tamanyo-1:0]     mplier_reg, mplier_next;
    logic [2*tamanyo-1:0]   acc_reg, acc_next;
    logic                   sign_reg, sign_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [tamanyo-1:0]     num_reg, num_next;
    logic                   done_reg, done_next;

    logic [tamanyo-1:0]     coc_mag, den_mag;
    logic [tamanyo-1:0]     sum_w;

    // Magnitude of the most-negative value is 2^(tamanyo-1), which still fits unsigned.
    assign coc_mag = coc_reg[tamanyo-1] ? (~coc_reg + ONE_W) : coc_reg;
    assign den_mag = den_reg[tamanyo-1] ? (~den_reg + ONE_W) : den_reg;

`ifdef RECOMPOSITOR_OVF_DETECT_EN
    logic [2*tamanyo:0]     prod_ext, prod_s, sum_full;
    logic [tamanyo+1:0]     sum_hi;
    logic                   ovf_reg, ovf_next, ovf_calc;

    assign prod_ext = {1'b0, acc_reg};
    assign prod_s   = sign_reg ? (~prod_ext + (2*tamanyo+1)'(1)) : prod_ext;
    assign sum_full = prod_s + {{(tamanyo+1){res_reg[tamanyo-1]}}, res_reg};
    assign sum_w    = sum_full[tamanyo-1:0];
    // In range only when every bit from the result msb upward is a copy of the sign.
    assign sum_hi   = sum_full[2*tamanyo:tamanyo-1];
    assign ovf_calc = !((&sum_hi) || !(|sum_hi));

    always_comb begin
        ovf_next = ovf_reg;
        if (state_reg == SUMA) begin
            ovf_next = ovf_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`else
    logic [tamanyo-1:0]     low_prod;

    // Only the low bits of the signed product matter for the wrapped result.
    assign low_prod = sign_reg ? (~acc_reg[tamanyo-1:0] + ONE_W) : acc_reg[tamanyo-1:0];
    assign sum_w    = low_prod + res_reg;
    assign ovf      = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        coc_next    = coc_reg;
        den_next    = den_reg;
        res_next    = res_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        sign_next   = sign_reg;
        cnt_next    = cnt_reg;
        num_next    = num_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    coc_next   = coc;
                    den_next   = den;
                    res_next   = res;
                    state_next = CARGA;
                end
            end
            CARGA: begin
                mcand_next  = {{tamanyo{1'b0}}, coc_mag};
                mplier_next = den_mag;
                sign_next   = coc_reg[tamanyo-1] ^ den_reg[tamanyo-1];
                acc_next    = '0;
                cnt_next    = '0;
                state_next  = ITERA;
            end
            ITERA: begin
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    state_next = SUMA;
                end
            end
            SUMA: begin
                num_next   = sum_w;
                done_next  = 1'b1;
                state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            coc_reg    <= '0;
            den_reg    <= '0;
            res_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            sign_reg   <= 1'b0;
            cnt_reg    <= '0;
            num_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            coc_reg    <= coc_next;
            den_reg    <= den_next;
            res_reg    <= res_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            sign_reg   <= sign_next;
            cnt_reg    <= cnt_next;
            num_reg    <= num_next;
            done_reg   <= done_next;
        end
    end

    assign num  = num_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_recompositor_division.sv
// Bench for recompositor_division: arithmetic reference model with per-cycle comparison,
// directed literal cases and randomized operand/start traffic.
module tb_recompositor_division;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  coc, den, res;
    logic [W-1:0]  num;
    logic          done;
    logic          ovf;

    recompositor_division #(.tamanyo(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .coc   (coc),
        .den   (den),
        .res   (res),
        .num   (num),
        .done  (done),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int           at_edge;
        logic [W-1:0] num;
        logic         ovf;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           next_accept = 0;
    logic [W-1:0] cur_num = '0;
    logic         cur_ovf = 1'b0;

`ifdef RECOMPOSITOR_OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact signed arithmetic, a request is taken only when the block is free.
    always @(posedge clk) begin
        int     n;
        longint p;
        exp_t   e;
        n = cyc + 1;
        cyc = n;
        if (!rst && start && n >= next_accept) begin
            p = longint'($signed(coc)) * longint'($signed(den)) + longint'($signed(res));
            e.at_edge = n;
            e.num     = p[W-1:0];
            e.ovf     = OVF_ON && ((p < -longint'(64'sd2147483648)) || (p > longint'(64'sd2147483647)));
            q.push_back(e);
            next_accept = n + W + 4;
        end
    end

    always @(negedge clk) begin
        logic exp_done;
        exp_done = 1'b0;
        if (!rst && q.size() > 0 && cyc == q[0].at_edge + W + 2) begin
            exp_done = 1'b1;
            cur_num  = q[0].num;
            cur_ovf  = q[0].ovf;
            $display("[TB] op from edge %0d: num=%h ovf=%b (dut num=%h ovf=%b)",
                     q[0].at_edge, cur_num, cur_ovf, num, ovf);
            void'(q.pop_front());
        end
        check("done", {63'd0, done}, {63'd0, exp_done});
        check("num", {32'd0, num}, {32'd0, cur_num});
        check("ovf", {63'd0, ovf}, {63'd0, cur_ovf});
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 20));
            5: return -W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] lit, input logic lit_ovf, input string name);
        int s_edge;
        @(negedge clk);
        coc = a; den = b; res = c; start = 1'b1;
        s_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60 && !done; k++) @(negedge clk);
        check({name, "_timeout"}, {63'd0, done}, 64'd1);
        if (done) begin
            check({name, "_latency"}, 64'(cyc - s_edge), 64'(W + 2));
            check({name, "_num"}, {32'd0, num}, {32'd0, lit});
            check({name, "_ovf"}, {63'd0, ovf}, {63'd0, lit_ovf});
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; coc = '0; den = '0; res = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op(32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 1'b0, "neg1x2");
        run_op(32'd1, 32'd2, 32'd0, 32'd2, 1'b0, "1x2");
        run_op(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEA, 1'b0, "7xm3m1");
        run_op(32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 1'b0, "minx1");
        run_op(32'h4000_0000, 32'd4, 32'd0, 32'd0, OVF_ON, "ovf4");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, OVF_ON, "minxm1");
        run_op(32'd0, 32'd5, 32'd3, 32'd3, 1'b0, "zero");
        run_op(32'd12345, 32'd0, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, "zeroden");

        // Second request in flight is ignored; operands changed one cycle after the start edge.
        @(negedge clk);
        coc = 32'd100; den = 32'd3; res = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; coc = 32'd9; den = 32'd9; res = 32'd9;
        repeat (9) @(negedge clk);
        start = 1'b1; coc = 32'd55; den = 32'd66;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60 && !done; k++) @(negedge clk);
        check("ignore_num", {32'd0, num}, 64'd307);
        repeat (40) @(negedge clk);

        // Mid-operation reset: outputs clear at once, no completion for the aborted op.
        @(negedge clk);
        coc = 32'd3; den = 32'd4; res = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        cur_num = '0; cur_ovf = 1'b0; next_accept = 0;
        #1;
        check("rst_async_num", {32'd0, num}, 64'd0);
        check("rst_async_done", {63'd0, done}, 64'd0);
        check("rst_async_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd1, 32'd31, 1'b0, "after_rst");

        // Randomized traffic, including a stretch with start held high.
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            coc = pick(); den = pick(); res = pick();
            start = (i >= 700 && i < 820) ? 1'b1 : ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 6) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
